// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target: oversampled SCL/SDA, 7-bit address match, register pointer,
// burst writes and sequential reads over a byte-wide register file.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned REG_DEPTH   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned AW         = $clog2(REG_DEPTH)
) (
    input  logic          clk_25MHz,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RACK      = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_r_c, scl_f_c, sda_r_c, sda_f_c;
    logic                   start_c, stop_c;

    logic [3:0]    state_q, state_nxt;
    logic [3:0]    bit_cnt_q, bit_cnt_nxt;
    logic [7:0]    shreg_q, shreg_nxt;
    logic [AW-1:0] ptr_q, ptr_nxt;
    logic          sda_oe_nxt, busy_nxt, wr_pulse_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic [7:0]    wr_data_nxt;
    logic [7:0]    rx_byte_c, rd_byte_c;

    logic [7:0]    regs [REG_DEPTH];

    // Synchronisers plus one extra copy for edge detection
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s   = scl_sync[SYNC_STAGES-1];
    assign sda_s   = sda_sync[SYNC_STAGES-1];
    assign scl_r_c = scl_s & ~scl_d;
    assign scl_f_c = ~scl_s & scl_d;
    assign sda_r_c = sda_s & ~sda_d;
    assign sda_f_c = ~sda_s & sda_d;
    // SCL stable high on both copies excludes a coincident SCL edge
    assign start_c = sda_f_c & scl_s & scl_d;
    assign stop_c  = sda_r_c & scl_s & scl_d;

    assign rx_byte_c = {shreg_q[6:0], sda_s};
    assign rd_byte_c = regs[ptr_q];

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 8'h00;
            ptr_q      <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
        end else begin
            state_q    <= state_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            shreg_q    <= shreg_nxt;
            ptr_q      <= ptr_nxt;
            sda_oe     <= sda_oe_nxt;
            busy       <= busy_nxt;
            wr_pulse   <= wr_pulse_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        bit_cnt_nxt  = bit_cnt_q;
        shreg_nxt    = shreg_q;
        ptr_nxt      = ptr_q;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        wr_pulse_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;

        if (stop_c) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start_c) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: if (scl_r_c) begin
                    shreg_nxt   = rx_byte_c;
                    bit_cnt_nxt = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_nxt = 4'd0;
                        if (rx_byte_c[7:1] == TARGET_ADDR) begin
                            state_nxt = ST_ADDR_ACK;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end
                end
                // ACK phases: sda_oe low means the ACK bit has not started yet
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: if (scl_f_c) begin
                    if (!sda_oe) begin
                        sda_oe_nxt = 1'b1;
                    end else begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 4'd0;
                        if (state_q == ST_ADDR_ACK && shreg_q[0]) begin
                            state_nxt  = ST_RDATA;
                            shreg_nxt  = rd_byte_c;
                            sda_oe_nxt = ~rd_byte_c[7];
                        end else if (state_q == ST_ADDR_ACK) begin
                            state_nxt = ST_REG;
                        end else begin
                            state_nxt = ST_WDATA;
                        end
                    end
                end
                ST_REG: if (scl_r_c) begin
                    shreg_nxt   = rx_byte_c;
                    bit_cnt_nxt = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        ptr_nxt   = rx_byte_c[AW-1:0];
                        state_nxt = ST_REG_ACK;
                    end
                end
                ST_WDATA: if (scl_r_c) begin
                    shreg_nxt   = rx_byte_c;
                    bit_cnt_nxt = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        wr_pulse_nxt = 1'b1;
                        wr_addr_nxt  = ptr_q;
                        wr_data_nxt  = rx_byte_c;
                        ptr_nxt      = ptr_q + AW'(1);
                        state_nxt    = ST_WDATA_ACK;
                    end
                end
                // bit_cnt counts bits already clocked out; MSB sits in shreg[7]
                ST_RDATA: begin
                    if (scl_r_c) begin
                        bit_cnt_nxt = bit_cnt_q + 4'd1;
                    end else if (scl_f_c) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = ST_RACK;
                        end else begin
                            shreg_nxt  = {shreg_q[6:0], shreg_q[7]};
                            sda_oe_nxt = ~shreg_q[6];
                        end
                    end
                end
                // Only an ACK keeps us here, so any falling edge starts the next byte
                ST_RACK: begin
                    if (scl_r_c) begin
                        if (sda_s) state_nxt = ST_IGNORE;
                        else       ptr_nxt   = ptr_q + AW'(1);
                    end else if (scl_f_c) begin
                        state_nxt   = ST_RDATA;
                        bit_cnt_nxt = 4'd0;
                        shreg_nxt   = rd_byte_c;
                        sda_oe_nxt  = ~rd_byte_c[7];
                    end
                end
                ST_IGNORE: sda_oe_nxt = 1'b0;
                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Register file and registered fabric read port
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_DEPTH); i++) regs[i] <= 8'h00;
            host_rdata <= 8'h00;
        end else begin
            if (wr_pulse_nxt) regs[wr_addr_nxt] <= wr_data_nxt;
            host_rdata <= regs[host_addr];
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Self-checking bench for i2c_target_regs: bit-banged I2C master against a
// transaction-level register/pointer model.
module tb_i2c_target_regs;

    localparam int unsigned Q = 5;

    logic       clk_25MHz = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    always #20 clk_25MHz = ~clk_25MHz;
    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mregs [16];
    logic [3:0] mptr;
    logic [11:0] wq [$];
    int         busy_cycles = 0;
    logic       last_oe;

    always @(negedge clk_25MHz) begin
        if (wr_pulse) wq.push_back({wr_addr, wr_data});
        if (busy) busy_cycles++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick(Q); scl_m = 1'b1; tick(Q);
        last_oe = sda_oe;
        tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        b = sda_line;
        tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        tick(1);
        d = host_rdata;
    endtask

    // Full write transaction; checks ACKs and the wr_pulse stream against the model
    task automatic do_write(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int n);
        logic        ack;
        logic [7:0]  d;
        logic [11:0] exp_w [3];
        int          base;
        base = wq.size();
        i2c_start();
        send_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ack got=%b exp=1", ack); end
        send_byte(p, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_reg_ack got=%b exp=1", ack); end
        mptr = p[3:0];
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            send_byte(d, ack);
            n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_data_ack[%0d] got=%b exp=1", k, ack); end
            exp_w[k] = {mptr, d};
            mregs[mptr] = d;
            mptr = mptr + 4'd1;
        end
        i2c_stop();
        tick(2);
        n_checks++;
        if (wq.size() - base !== n) begin
            n_fail++; $display("FAIL wr_pulse_count got=%0d exp=%0d", wq.size() - base, n);
        end else begin
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (wq[base+k] !== exp_w[k]) begin
                    n_fail++; $display("FAIL wr_pulse[%0d] got=%h exp=%h", k, wq[base+k], exp_w[k]);
                end
            end
        end
    endtask

    // Read transaction of n bytes (ACK all but last), optional pointer set first
    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            send_byte(8'hA0, ack);
            n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_waddr_ack got=%b exp=1", ack); end
            send_byte(p, ack);
            n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_reg_ack got=%b exp=1", ack); end
            mptr = p[3:0];
            i2c_start();
        end
        send_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack got=%b exp=1", ack); end
        for (int k = 0; k < n; k++) begin
            recv_byte(d, k < n - 1);
            n_checks++;
            if (d !== mregs[mptr]) begin
                n_fail++; $display("FAIL rd_data[%0d] ptr=%0d got=%h exp=%h", k, mptr, d, mregs[mptr]);
            end
            n_checks++;
            if (last_oe !== 1'b0) begin n_fail++; $display("FAIL rd_master_ack_bit oe got=%b exp=0", last_oe); end
            if (k < n - 1) mptr = mptr + 4'd1;
        end
        i2c_stop();
        tick(2);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_addr = 4'd0;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 4'd0;
        tick(3);
        n_checks++; if (sda_oe !== 1'b0)     begin n_fail++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
        n_checks++; if (wr_pulse !== 1'b0)   begin n_fail++; $display("FAIL rst_wr_pulse got=%b exp=0", wr_pulse); end
        n_checks++; if (wr_addr !== 4'd0)    begin n_fail++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
        n_checks++; if (wr_data !== 8'h00)   begin n_fail++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_host_rdata got=%h exp=0", host_rdata); end
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            host_read(4'(i), d);
            n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_reg[%0d] got=%h exp=00", i, d); end
        end
    endtask

    task automatic test_write();
        logic [7:0] d;
        int b0;
        b0 = busy_cycles;
        do_write(8'h03, 8'hAC, 8'h00, 8'h00, 1);
        host_read(4'd3, d);
        n_checks++; if (d !== 8'hAC) begin n_fail++; $display("FAIL write_host_rdata got=%h exp=ac", d); end
        n_checks++; if (busy_cycles == b0) begin n_fail++; $display("FAIL write_busy got=never exp=asserted"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack got=%b exp=1", ack); end
        recv_byte(d, 1'b0);
        n_checks++; if (d !== 8'hAC) begin n_fail++; $display("FAIL read_data got=%h exp=ac", d); end
        n_checks++; if (last_oe !== 1'b0) begin n_fail++; $display("FAIL read_nack_bit_oe got=%b exp=0", last_oe); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_after_nack_oe got=%b exp=0", sda_oe); end
        recv_byte(d, 1'b0);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_ignore_released got=%h exp=ff", d); end
        i2c_stop();
        tick(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_stop got=%b exp=0", busy); end
        mptr = 4'd3;
    endtask

    task automatic test_mismatch();
        logic ack;
        int   b0, w0;
        b0 = busy_cycles; w0 = wq.size();
        i2c_start();
        send_byte(8'hA2, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mismatch_ack got=%b exp=0", ack); end
        send_byte(8'h12, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mismatch_data_ack got=%b exp=0", ack); end
        i2c_stop();
        i2c_start();
        send_byte(8'h00, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL general_call_ack got=%b exp=0", ack); end
        i2c_stop();
        tick(2);
        n_checks++; if (busy_cycles != b0) begin n_fail++; $display("FAIL mismatch_busy cycles=%0d exp=0", busy_cycles - b0); end
        n_checks++; if (wq.size() != w0) begin n_fail++; $display("FAIL mismatch_wr_pulse got=%0d exp=0", wq.size() - w0); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        do_write(8'h0F, 8'h11, 8'h22, 8'h00, 2);
        host_read(4'd15, d);
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL wrap_reg15 got=%h exp=11", d); end
        host_read(4'd0, d);
        n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL wrap_reg0 got=%h exp=22", d); end
        do_read(1'b1, 8'h0F, 2);
    endtask

    task automatic test_abort();
        logic       ack;
        logic [7:0] v, d;
        int         w0;
        v = 8'($urandom);
        do_write(8'h05, v, 8'h00, 8'h00, 1);
        w0 = wq.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        mptr = 4'd5;
        for (int i = 7; i >= 4; i--) send_bit(~v[i]);
        i2c_start();
        send_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL abort_readdr_ack got=%b exp=1", ack); end
        recv_byte(d, 1'b0);
        n_checks++; if (d !== mregs[5]) begin n_fail++; $display("FAIL abort_read got=%h exp=%h", d, mregs[5]); end
        i2c_stop();
        tick(2);
        n_checks++; if (wq.size() != w0) begin n_fail++; $display("FAIL abort_wr_pulse got=%0d exp=0", wq.size() - w0); end
        host_read(4'd5, d);
        n_checks++; if (d !== v) begin n_fail++; $display("FAIL abort_reg5 got=%h exp=%h", d, v); end
    endtask

    task automatic test_random();
        logic       ack;
        logic [6:0] a;
        logic [7:0] d;
        logic [3:0] ha;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0: do_write(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                            int'($urandom_range(1, 3)));
                1: do_read(1'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
                default: begin
                    a = 7'($urandom);
                    if (a == 7'h50) a = 7'h51;
                    i2c_start();
                    send_byte({a, 1'($urandom)}, ack);
                    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rand_mismatch_ack addr=%h got=%b exp=0", a, ack); end
                    i2c_stop();
                end
            endcase
            ha = 4'($urandom);
            host_read(ha, d);
            n_checks++; if (d !== mregs[ha]) begin n_fail++; $display("FAIL rand_host_rdata[%0d] got=%h exp=%h", ha, d, mregs[ha]); end
        end
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic [7:0] d;
        int         cnt;
        do_write(8'h07, 8'h3C, 8'h00, 8'h00, 1);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h07, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        cnt = 0;
        while (sda_oe !== 1'b1 && cnt < 50) begin tick(1); cnt++; end
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_driving got=%b exp=1", sda_oe); end
        #7 rst_n = 1'b0;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_async_oe got=%b exp=0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_checks++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_host_rdata got=%h exp=0", host_rdata); end
        n_checks++; if (wr_addr !== 4'd0 || wr_data !== 8'h00) begin
            n_fail++; $display("FAIL midrst_wr_bus got=%h/%h exp=0/00", wr_addr, wr_data);
        end
        scl_m = 1'b1; sda_m = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 4'd0;
        host_read(4'd7, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL midrst_reg7 got=%h exp=00", d); end
        do_write(8'h02, 8'h5A, 8'h00, 8'h00, 1);
        do_read(1'b0, 8'h00, 1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_abort();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
